ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-lite memory slave, next generation of our AHB slave memory. Byte-addressed internal SRAM array.
//  Adds the following over the previous slave:
//   - parametrised data width;
//   - selectable endianness with proper byte-lane steering;
//   - registered read data with write-to-read forwarding;
//   - two-cycle ERROR response for illegal transfers.
//  Sits behind the AHB decoder/mux as one of N slaves. Zero-wait or fixed-wait-state operation.
// PARAMETERS
//  ADDR_WIDTH           32    address bus width
//  DATA_WIDTH           32    data bus width; 32 or 64; NBYTES=DATA_WIDTH/8
//  MEMORY_DEPTH         1024  memory size in bytes; multiple of NBYTES
//  REGISTER_SELECT_BITS 12    low address bits used as memory offset; upper bits ignored (decoder's job)
//  WAIT_WRITE           0     wait states inserted in every write data phase (0..15)
//  WAIT_READ            0     wait states inserted in every read data phase (0..15)
//  BIG_ENDIAN           1     1: byte at offset 0 of a word on lane NBYTES-1 (MSB); 0: on lane 0 (LSB)
// PORTS
//  i_hclk       in   1           clock; all logic on rising edge
//  i_hreset     in   1           synchronous active-low reset
//  i_hsel       in   1           slave select from decoder
//  i_haddr      in   ADDR_WIDTH  address
//  i_hwrite     in   1           1=write, 0=read
//  i_hsize      in   3           transfer size: 000 byte, 001 half, 010 word, 011 dword
//  i_htrans     in   2           IDLE 00, BUSY 01, NONSEQ 10, SEQ 11
//  i_hreadyin   in   1           bus HREADY (previous transfer complete)
//  i_hwdata     in   DATA_WIDTH  write data
//  o_hreadyout  out  1           slave ready
//  o_hresp      out  1           0=OKAY, 1=ERROR
//  o_hrdata     out  DATA_WIDTH  read data, registered
// BEHAVIOUR
//  Reset:
//   - i_hreset=0 at a rising edge sets o_hreadyout=1, o_hresp=0, o_hrdata=0 and state=IDLE.
//   - Wait counter cleared; memory cleared to 0.
//   - Reset during a data phase aborts it; no partial write occurs.
//  Address phase accept:
//   - Accept when i_hsel & i_hreadyin & i_htrans[1].
//   - Register addr offset (i_haddr[REGISTER_SELECT_BITS-1:0]), size and write.
//  IDLE/BUSY or unselected:
//   - No memory action; next data phase is zero-wait OKAY.
//  Legality check, at accept:
//   - ERROR if size > log2(NBYTES).
//   - ERROR if addr is not aligned to size.
//   - ERROR if offset+bytes > MEMORY_DEPTH.
//  FSM states: IDLE, WAIT, ERR1, ERR2.
//   - IDLE: o_hreadyout=1, o_hresp=0.
//     - Legal accept with wait count >0 -> WAIT.
//     - Legal accept with wait count 0 -> completes next cycle, state stays IDLE.
//     - Illegal accept -> ERR1.
//   - WAIT: o_hreadyout=0, o_hresp=0 for exactly WAIT_WRITE or WAIT_READ cycles, then ready=1 for one cycle.
//     - Returns to IDLE on that ready cycle; a new accept on the ready cycle is handled as from IDLE.
//   - ERR1: o_hreadyout=0, o_hresp=1 for one cycle -> ERR2.
//   - ERR2: o_hreadyout=1, o_hresp=1 for one cycle -> IDLE.
//     - An accept in ERR2 is honoured (master may cancel via IDLE).
//  Write:
//   - i_hwdata is captured on the data-phase cycle where o_hreadyout=1.
//   - Bytes are written at that same edge.
//   - Only lanes selected by size and addr[log2(NBYTES)-1:0] per BIG_ENDIAN; other bytes untouched.
//   - Illegal transfers never write.
//  Read:
//   - o_hrdata is loaded at the edge that opens the ready cycle and is valid while o_hreadyout=1.
//   - Unselected lanes are 0.
//   - Lane mapping mirrors write.
//   - o_hrdata holds its value otherwise. ERROR reads drive 0.
//  Forwarding:
//   - Applies when a read's data load coincides with the edge committing a write to overlapping bytes.
//   - The new write bytes are returned per byte. Zero-wait write->read to the same address returns the new data.
//  Back-to-back pipelined NONSEQ/SEQ transfers sustain 1 transfer/cycle when WAIT_*=0.
// TESTING
//  1. DATA_WIDTH=32, BIG_ENDIAN=1: write word 0xA1B2C3D4 @0x10, then read byte @0x11
//     -> o_hrdata=0x00B20000, OKAY, zero wait.
//  2. BIG_ENDIAN=0: write half 0xBEEF @0x12, then read word @0x10
//     -> o_hrdata=0xBEEF0000 (other bytes reset 0).
//  3. Pipelined write 0x11223344 @0x20 immediately followed by read word @0x20
//     -> o_hrdata=0x11223344 (forwarding).
//  4. Illegal accesses:
//     - word @0x02 (misaligned) -> ready=0/hresp=1, then ready=1/hresp=1; memory unchanged.
//     - dword on 32-bit bus -> same two-cycle ERROR.
//     - word @MEMORY_DEPTH-2 -> same two-cycle ERROR.
//  5. WAIT_READ=3, WAIT_WRITE=2:
//     - read -> exactly 3 cycles hreadyout=0, then data.
//     - write -> 2 low cycles; data captured on ready cycle only.
//  6. Reset asserted during a WAIT cycle of a write
//     -> no bytes written; outputs ready=1, hresp=0, hrdata=0 next cycle.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus bundle between a master/decoder and the SRAM slave.
// Clock and reset stay outside the bundle as plain ports.
interface ahb_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_hsel;
  logic [ADDR_WIDTH-1:0] i_haddr;
  logic                  i_hwrite;
  logic [2:0]            i_hsize;
  logic [1:0]            i_htrans;
  logic                  i_hreadyin;
  logic [DATA_WIDTH-1:0] i_hwdata;
  logic                  o_hreadyout;
  logic                  o_hresp;
  logic [DATA_WIDTH-1:0] o_hrdata;

  modport slave (
    input  i_hsel, i_haddr, i_hwrite, i_hsize, i_htrans, i_hreadyin, i_hwdata,
    output o_hreadyout, o_hresp, o_hrdata
  );

  modport master (
    output i_hsel, i_haddr, i_hwrite, i_hsize, i_htrans, i_hreadyin, i_hwdata,
    input  o_hreadyout, o_hresp, o_hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-lite byte-addressed SRAM slave: endian-aware lane steering, fixed wait states,
// registered read data with write-to-read forwarding, two-cycle ERROR response.
//
// state  | meaning
// IDLE   | ready/OKAY; completes zero-wait data phases and accepts new transfers
// WAIT   | inserting wait states (ready=0) for the current data phase
// ERR1   | first ERROR cycle (ready=0, resp=1)
// ERR2   | second ERROR cycle (ready=1, resp=1); may accept a new transfer
module ahb_sram_slave #(
  parameter int ADDR_WIDTH           = 32,
  parameter int DATA_WIDTH           = 32,
  parameter int MEMORY_DEPTH         = 1024,
  parameter int REGISTER_SELECT_BITS = 12,
  parameter int WAIT_WRITE           = 0,
  parameter int WAIT_READ            = 0,
  parameter int BIG_ENDIAN           = 1
) (
  input logic          i_hclk,
  input logic          i_hreset,
  ahb_sram_slave_if.slave bus
);
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int OW     = REGISTER_SELECT_BITS;
  localparam int MW     = $clog2(MEMORY_DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(LB);
  localparam logic [3:0] WW = 4'(WAIT_WRITE);
  localparam logic [3:0] WR = 4'(WAIT_READ);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt, cnt_nx, wait_n;
  logic                dp_valid, dp_valid_nx, dp_write;
  logic [OW-1:0]       dp_off;
  logic [2:0]          dp_size;
  logic [7:0]          mem [MEMORY_DEPTH];

  logic                accept, legal, wr_commit, rd_load, same_word;
  logic [31:0]         off32, len32;
  logic [OW-1:0]       rd_off;
  logic [2:0]          rd_size;
  logic [NBYTES-1:0]   rd_sel, wr_sel;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                unused_bits;

  assign unused_bits = ^{bus.i_haddr, bus.i_htrans};

  // Lanes touched by a transfer; byte offset 0 sits on the top lane when big-endian.
  function automatic logic [NBYTES-1:0] lane_sel(input logic [OW-1:0] off, input logic [2:0] size);
    logic [NBYTES-1:0] sel;
    int lo, len, b;
    lo  = int'(off[LB-1:0]);
    len = 1 << size;
    for (int l = 0; l < NBYTES; l++) begin
      b      = (BIG_ENDIAN != 0) ? NBYTES - 1 - l : l;
      sel[l] = (b >= lo) && (b < lo + len);
    end
    return sel;
  endfunction

  function automatic logic [MW-1:0] byte_idx(input logic [OW-1:0] off, input int lane);
    logic [MW-1:0] base;
    int b;
    base = off[MW-1:0] & ~MW'(NBYTES - 1);
    b    = (BIG_ENDIAN != 0) ? NBYTES - 1 - lane : lane;
    return base + MW'(b);
  endfunction

  always_comb begin
    off32  = 32'(bus.i_haddr[OW-1:0]);
    len32  = 32'd1 << bus.i_hsize;
    legal  = (bus.i_hsize <= MAX_SIZE) && ((off32 & (len32 - 32'd1)) == 32'd0) &&
             (off32 + len32 <= 32'(MEMORY_DEPTH));
    accept = bus.i_hsel && bus.i_hreadyin && bus.i_htrans[1] &&
             (state == S_IDLE || state == S_ERR2);
  end

  assign wait_n = bus.i_hwrite ? WW : WR;

  // Read data is sampled either at accept (zero-wait) or when the last wait state ends.
  always_comb begin
    wr_commit = (state == S_IDLE) && dp_valid && dp_write;
    wr_sel    = lane_sel(dp_off, dp_size);
    if (state == S_WAIT) begin
      rd_off  = dp_off;
      rd_size = dp_size;
      rd_load = (cnt == 4'd0) && !dp_write;
    end else begin
      rd_off  = bus.i_haddr[OW-1:0];
      rd_size = bus.i_hsize;
      rd_load = accept && legal && !bus.i_hwrite && (WR == 4'd0);
    end
    rd_sel    = lane_sel(rd_off, rd_size);
    same_word = byte_idx(dp_off, 0) == byte_idx(rd_off, 0);
    rd_data   = '0;
    for (int l = 0; l < NBYTES; l++) begin
      if (rd_sel[l]) begin
        if (wr_commit && same_word && wr_sel[l])
          rd_data[8*l +: 8] = bus.i_hwdata[8*l +: 8];
        else
          rd_data[8*l +: 8] = mem[byte_idx(rd_off, l)];
      end
    end
  end

  always_comb begin
    state_nx        = state;
    cnt_nx          = cnt;
    dp_valid_nx     = dp_valid;
    bus.o_hreadyout = 1'b1;
    bus.o_hresp     = 1'b0;
    case (state)
      S_IDLE, S_ERR2: begin
        if (state == S_ERR2) begin
          bus.o_hresp = 1'b1;
          state_nx    = S_IDLE;
        end
        dp_valid_nx = 1'b0;
        if (accept) begin
          if (!legal) begin
            state_nx = S_ERR1;
          end else begin
            dp_valid_nx = 1'b1;
            if (wait_n != 4'd0) begin
              state_nx = S_WAIT;
              cnt_nx   = wait_n - 4'd1;
            end
          end
        end
      end
      S_WAIT: begin
        bus.o_hreadyout = 1'b0;
        if (cnt == 4'd0) state_nx = S_IDLE;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_ERR1: begin
        bus.o_hreadyout = 1'b0;
        bus.o_hresp     = 1'b1;
        state_nx        = S_ERR2;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_hclk) begin
    if (!i_hreset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      dp_valid     <= 1'b0;
      dp_write     <= 1'b0;
      dp_off       <= '0;
      dp_size      <= 3'd0;
      bus.o_hrdata <= '0;
      for (int i = 0; i < MEMORY_DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      dp_valid <= dp_valid_nx;
      if (accept) begin
        dp_write <= bus.i_hwrite;
        dp_off   <= bus.i_haddr[OW-1:0];
        dp_size  <= bus.i_hsize;
      end
      if (rd_load)
        bus.o_hrdata <= rd_data;
      else if (accept && !legal && !bus.i_hwrite)
        bus.o_hrdata <= '0;
      if (wr_commit) begin
        for (int l = 0; l < NBYTES; l++)
          if (wr_sel[l]) mem[byte_idx(dp_off, l)] <= bus.i_hwdata[8*l +: 8];
      end
    end
  end
endmodule
